// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types and channel helpers for the tick scheduler
package tick_sched_pkg;

  // Channel counters are stored at this width; the top zero-extends CNT_W into it.
  localparam int unsigned CNT_W_MAX = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_t;

  typedef enum logic [1:0] {
    OP_STOP     = 2'b00,
    OP_ONESHOT  = 2'b01,
    OP_PERIODIC = 2'b10,
    OP_RSVD     = 2'b11
  } cfg_op_t;

  typedef struct packed {
    logic                 active;
    logic                 periodic;
    logic [CNT_W_MAX-1:0] period;
    logic [CNT_W_MAX-1:0] remaining;
  } chan_t;

  // A channel fires in the scan slot where its countdown sits at 1.
  function automatic logic chan_fires(input chan_t c);
    return c.active && (c.remaining == CNT_W_MAX'(1));
  endfunction

  // State of a channel after its scan slot; remaining never drops below 1 while active.
  function automatic chan_t chan_step(input chan_t c);
    chan_t n;
    n = c;
    if (c.active) begin
      if (c.remaining == CNT_W_MAX'(1)) begin
        if (c.periodic) n.remaining = c.period;
        else            n.active    = 1'b0;
      end else begin
        n.remaining = c.remaining - CNT_W_MAX'(1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle tick every PRESCALE clocks
module tick_prescaler #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Count 0..PRESCALE-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - multi-channel tick scheduler on a shared timebase; optional TICK_SCHED_HEARTBEAT_EN adds heartbeat
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [1:0]              cfg_op,
  input  logic [CNT_W-1:0]        cfg_period,
  output logic                    tick,
  output logic [NCH-1:0]          ch_fire,
  output logic [NCH-1:0]          ch_busy
`ifdef TICK_SCHED_HEARTBEAT_EN
  ,
  output logic                    heartbeat
`endif
);

  localparam int unsigned CH_W = $clog2(NCH);
  localparam logic [CH_W:0] NCH_V   = (CH_W + 1)'(NCH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  if (NCH < 2 || NCH > 16) begin : g_bad_nch
    $error("tick_sched: NCH must be within 2..16");
  end
  if (PRESCALE <= NCH + 1) begin : g_bad_prescale
    $error("tick_sched: PRESCALE must exceed NCH+1 so a scan finishes before the next tick");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("tick_sched: CNT_W out of range");
  end

  sched_state_t    state, state_n;
  logic [CH_W-1:0] idx, idx_n;
  logic            scan_en;
  logic            cfg_fire;
  logic            cfg_in_range;
  cfg_op_t         op;
  chan_t           chans [NCH];

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign op           = cfg_op_t'(cfg_op);
  assign cfg_fire     = cfg_valid && cfg_ready;
  assign cfg_in_range = ({1'b0, cfg_ch} < NCH_V);

  // FSM state and scan index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next state: a tick launches a scan that visits each channel once, one per cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (tick) begin
          state_n = SCAN;
          idx_n   = '0;
        end
      end
      SCAN: begin
        if (idx == LAST_CH) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + CH_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs: config is only taken while idle and off the tick; fire is decoded from the visited slot.
  always_comb begin
    cfg_ready = 1'b0;
    scan_en   = 1'b0;
    ch_fire   = '0;
    case (state)
      IDLE: cfg_ready = !tick;
      SCAN: begin
        scan_en      = 1'b1;
        ch_fire[idx] = chan_fires(chans[idx]);
      end
      default: ;
    endcase
  end

  // Channel table: the scan advances one slot per cycle; config writes only land outside scans.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) chans[i] <= '0;
    end else if (scan_en) begin
      chans[idx] <= chan_step(chans[idx]);
    end else if (cfg_fire && cfg_in_range) begin
      case (op)
        OP_ONESHOT, OP_PERIODIC: begin
          if (cfg_period != '0) begin
            chans[cfg_ch] <= '{active:    1'b1,
                               periodic:  (op == OP_PERIODIC),
                               period:    CNT_W_MAX'(cfg_period),
                               remaining: CNT_W_MAX'(cfg_period)};
          end else begin
            chans[cfg_ch].active <= 1'b0;
          end
        end
        OP_STOP: chans[cfg_ch].active <= 1'b0;
        default: ;
      endcase
    end
  end

  // Busy mirrors the stored active bits.
  always_comb begin
    ch_busy = '0;
    for (int i = 0; i < int'(NCH); i++) ch_busy[i] = chans[i].active;
  end

`ifdef TICK_SCHED_HEARTBEAT_EN
  // Toggle once per tick: square wave with period 2*PRESCALE.
  always_ff @(posedge clk) begin
    if (rst)       heartbeat <= 1'b0;
    else if (tick) heartbeat <= ~heartbeat;
  end
`endif

endmodule

// File: tb/tb_tick_sched.sv
// tb/tb_tick_sched.sv - randomized self-checking bench for tick_sched against a tick-counting model
module tb_tick_sched;

  localparam int NCH      = 4;
  localparam int PRESCALE = 8;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_op = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             tick;
  logic [NCH-1:0]   ch_fire;
  logic [NCH-1:0]   ch_busy;
`ifdef TICK_SCHED_HEARTBEAT_EN
  logic             heartbeat;
`endif

  tick_sched #(.NCH(NCH), .PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_op     (cfg_op),
    .cfg_period (cfg_period),
    .tick       (tick),
    .ch_fire    (ch_fire),
    .ch_busy    (ch_busy)
`ifdef TICK_SCHED_HEARTBEAT_EN
    ,
    .heartbeat  (heartbeat)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: each channel counts ticks seen since its start and fires on reaching its period.
  bit m_act     [NCH];
  bit m_per     [NCH];
  int m_period  [NCH];
  int m_seen    [NCH];
  int m_fire_at [NCH];
  int m_off_at  [NCH];
  int m_last_tick;
  bit m_hb;
  bit m_accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_act[k]     = 1'b0;
      m_per[k]     = 1'b0;
      m_period[k]  = 0;
      m_seen[k]    = 0;
      m_fire_at[k] = -1;
      m_off_at[k]  = -1;
    end
    m_last_tick = -100;
    m_hb        = 1'b0;
    m_accepted  = 1'b0;
  endfunction

  // Compare one cycle at the falling edge, then advance the model across the next rising edge.
  task automatic run_cycle();
    bit             e_tick;
    bit             e_ready;
    logic [NCH-1:0] e_fire;
    logic [NCH-1:0] e_busy;
    @(negedge clk);
    e_tick  = (cyc % PRESCALE) == PRESCALE - 1;
    e_ready = !e_tick && !((cyc - m_last_tick) >= 1 && (cyc - m_last_tick) <= NCH);
    for (int k = 0; k < NCH; k++) begin
      e_fire[k] = (m_fire_at[k] == cyc);
      e_busy[k] = m_act[k];
    end
    check("tick", 32'(tick), 32'(e_tick));
    check("cfg_ready", 32'(cfg_ready), 32'(e_ready));
    check("ch_fire", 32'(ch_fire), 32'(e_fire));
    check("ch_busy", 32'(ch_busy), 32'(e_busy));
`ifdef TICK_SCHED_HEARTBEAT_EN
    check("heartbeat", 32'(heartbeat), 32'(m_hb));
`endif
    m_accepted = 1'b0;
    if (e_tick) begin
      m_last_tick = cyc;
      m_hb = !m_hb;
      for (int k = 0; k < NCH; k++) begin
        if (m_act[k]) begin
          m_seen[k]++;
          if (m_seen[k] == m_period[k]) begin
            m_fire_at[k] = cyc + 1 + k;
            if (m_per[k]) m_seen[k] = 0;
            else          m_off_at[k] = cyc + 1 + k;
          end
        end
      end
    end
    for (int k = 0; k < NCH; k++)
      if (m_act[k] && m_off_at[k] == cyc) m_act[k] = 1'b0;
    if (cfg_valid && e_ready) begin
      m_accepted = 1'b1;
      if ((cfg_op == 2'b01 || cfg_op == 2'b10) && cfg_period != 0) begin
        m_act[cfg_ch]    = 1'b1;
        m_per[cfg_ch]    = (cfg_op == 2'b10);
        m_period[cfg_ch] = int'(cfg_period);
        m_seen[cfg_ch]   = 0;
        m_off_at[cfg_ch] = -1;
      end else if (cfg_op != 2'b11) begin
        m_act[cfg_ch] = 1'b0;
      end
    end
    if (rst) begin
      model_reset();
      cyc = 0;
    end else begin
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Present a config and hold it until the model says it was taken.
  task automatic do_cfg(input int ch, input int op, input int per);
    int n;
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_op     = 2'(op);
    cfg_period = CNT_W'(per);
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!m_accepted && n < 40);
    if (!m_accepted) check("cfg_timeout", 32'(0), 32'(1));
    cfg_valid = 1'b0;
  endtask

  task automatic run_until_phase(input int ph);
    int n;
    n = 0;
    while ((cyc % PRESCALE) != ph && n < 2 * PRESCALE) begin
      run_cycle();
      n++;
    end
    if ((cyc % PRESCALE) != ph) check("phase_timeout", 32'(cyc % PRESCALE), 32'(ph));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    run_cycle();
    rst = 1'b0;

    run_n(40);

    do_cfg(2, 2, 3);
    run_n(10 * PRESCALE);

    do_cfg(0, 1, 1);
    run_n(3 * PRESCALE);

    do_cfg(1, 1, 0);
    do_cfg(3, 2, 5);
    run_n(2 * PRESCALE);
    do_cfg(3, 0, 0);
    run_n(6 * PRESCALE);
    do_cfg(2, 0, 0);

    run_until_phase(PRESCALE - 1);
    do_cfg(1, 2, 2);
    run_n(5 * PRESCALE);

    for (int i = 0; i < 1500; i++) begin
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid  = 1'b1;
        cfg_ch     = 2'($urandom_range(0, 3));
        cfg_op     = 2'($urandom_range(0, 3));
        cfg_period = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      end
      run_cycle();
      if (m_accepted) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;

    do_cfg(1, 2, 1);
    do_cfg(3, 2, 1);
    run_until_phase(1);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run_n(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
